// File: rtl/imem_load_arbiter_if.sv
// Bus bundle for imem_load_arbiter: loader byte stream, fetch port and memory port.
// With IMEM_LOAD_CHECKSUM_EN defined it also carries ld_csum / ld_csum_exp.
interface imem_load_arbiter_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ld_start;
  logic             ld_byte_valid;
  logic [7:0]       ld_byte;
  logic             ld_done;
  logic             ld_busy;
  logic             ld_ovf;
  logic [CNT_W-1:0] ld_word_count;
  logic             core_hold;
  logic             f_req;
  logic [31:0]      f_addr;
  logic             f_ack;
  logic [31:0]      f_data;
  logic             f_err;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]       ld_csum;
  logic [7:0]       ld_csum_exp;
`endif

  // Requester/memory side of the bundle.
  modport master (
    output ld_start, ld_byte_valid, ld_byte, ld_done, f_req, f_addr, mem_rdata,
    input  ld_busy, ld_ovf, ld_word_count, core_hold, f_ack, f_data, f_err,
    input  mem_we, mem_addr, mem_wdata
`ifdef IMEM_LOAD_CHECKSUM_EN
    , output ld_csum_exp, input ld_csum
`endif
  );

  // Arbiter side of the bundle.
  modport slave (
    input  ld_start, ld_byte_valid, ld_byte, ld_done, f_req, f_addr, mem_rdata,
    output ld_busy, ld_ovf, ld_word_count, core_hold, f_ack, f_data, f_err,
    output mem_we, mem_addr, mem_wdata
`ifdef IMEM_LOAD_CHECKSUM_EN
    , input ld_csum_exp, output ld_csum
`endif
  );
endinterface

// File: rtl/imem_load_arbiter.sv
// Shares the instruction memory port between the byte-stream program loader and fetch.
// Optional IMEM_LOAD_CHECKSUM_EN: load checksum output and mismatch hold-off.
module imem_load_arbiter #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  imem_load_arbiter_if.slave bus
);
  localparam logic [31:0]      NOP_INSN  = 32'h0000_0013;
  localparam logic [31:0]      MEM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [23:0]      asm_q, asm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             we_q, we_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [31:0]      fdata_q, fdata_d;
  logic             hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             done_ok;
  logic             f_go;
  logic             f_bad;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
  logic             csum_bad_q, csum_bad_d;
`endif

  assign f_go  = (state_q == RUN) && bus.f_req;
  assign f_bad = (bus.f_addr[1:0] != 2'b00) || (bus.f_addr >= MEM_BYTES);

  // Next state, byte assembly, write issue and fetch response.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_ok = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
    csum_d     = csum_q;
    csum_bad_d = csum_bad_q;
`endif

    unique case (state_q)
      LOAD: begin
        if (bus.ld_byte_valid) begin
          if (cnt_q == CNT_FULL) begin
            ovf_d = 1'b1;
          end else begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_d = csum_q + bus.ld_byte;
`endif
            unique case (lane_q)
              2'd0: asm_d[7:0]   = bus.ld_byte;
              2'd1: asm_d[15:8]  = bus.ld_byte;
              2'd2: asm_d[23:16] = bus.ld_byte;
              default: begin
                we_d    = 1'b1;
                waddr_d = 32'({cnt_q, 2'b00});
                wdata_d = {bus.ld_byte, asm_q};
                cnt_d   = cnt_q + CNT_W'(1);
                asm_d   = '0;
              end
            endcase
            lane_d = lane_q + 2'd1;
          end
        end
        // End of stream: pad a partial word with zero lanes and write it out.
        if (bus.ld_done) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          csum_bad_d = (csum_d != bus.ld_csum_exp);
          done_ok    = !csum_bad_d;
`endif
          if (lane_d != 2'd0) begin
            we_d    = 1'b1;
            waddr_d = 32'({cnt_q, 2'b00});
            wdata_d = {8'h00, asm_d};
            cnt_d   = cnt_q + CNT_W'(1);
            asm_d   = '0;
            lane_d  = 2'd0;
          end
          if (we_d) begin
            state_d = FLUSH;
          end else begin
            state_d = done_ok ? RUN : IDLE;
          end
        end
      end
      FLUSH: begin
        state_d = RUN;
`ifdef IMEM_LOAD_CHECKSUM_EN
        if (csum_bad_q) state_d = IDLE;
`endif
      end
      default: ;
    endcase

    // A start from any state begins a fresh load and drops any partial word.
    if (bus.ld_start) begin
      state_d = LOAD;
      lane_d  = 2'd0;
      asm_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      we_d    = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_d     = 8'h00;
      csum_bad_d = 1'b0;
`endif
    end

    hold_d  = (state_d != RUN);
    busy_d  = (state_d == LOAD) || (state_d == FLUSH);

    ack_d   = f_go;
    err_d   = f_go && f_bad;
    fdata_d = fdata_q;
    if (f_go) fdata_d = f_bad ? NOP_INSN : bus.mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
      asm_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      fdata_q <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q     <= 8'h00;
      csum_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      fdata_q <= fdata_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q     <= csum_d;
      csum_bad_q <= csum_bad_d;
`endif
    end
  end

  // Writes only occur in LOAD/FLUSH, so the write address never collides with a fetch.
  assign bus.mem_addr      = we_q ? waddr_q : ((f_go && !f_bad) ? bus.f_addr : 32'h0);
  assign bus.mem_we        = we_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.ld_busy       = busy_q;
  assign bus.ld_ovf        = ovf_q;
  assign bus.ld_word_count = cnt_q;
  assign bus.core_hold     = hold_q;
  assign bus.f_ack         = ack_q;
  assign bus.f_err         = err_q;
  assign bus.f_data        = fdata_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign bus.ld_csum       = csum_q;
`endif
endmodule

// File: tb/tb_imem_load_arbiter.sv
// Scoreboard bench for imem_load_arbiter: a full-size instance plus a 4-word instance
// for the memory-full case. Expected writes/fetches are queued; a monitor compares them.
module tb_imem_load_arbiter;
  logic clk = 1'b0;
  logic reset;

  imem_load_arbiter_if #(.CNT_W(16)) bus ();
  imem_load_arbiter_if #(.CNT_W(16)) sb ();

  imem_load_arbiter #(.DEPTH_WORDS(1024), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  imem_load_arbiter #(.DEPTH_WORDS(4), .CNT_W(16)) dut_s (
    .clk(clk), .reset(reset), .bus(sb)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [4];

  assign bus.mem_rdata = mem_a[bus.mem_addr[11:2]];
  assign sb.mem_rdata  = mem_b[sb.mem_addr[3:2]];

  always @(posedge clk) begin
    if (bus.mem_we) mem_a[bus.mem_addr[11:2]] <= bus.mem_wdata;
    if (sb.mem_we)  mem_b[sb.mem_addr[3:2]]   <= sb.mem_wdata;
  end

  int checks = 0;
  int errors = 0;
  logic [63:0] wq [$];
  logic [63:0] sq [$];
  logic [63:0] fq [$];
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0] csum_acc = 8'h00;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic st, input logic bv, input logic [7:0] b, input logic dn);
    bus.ld_start      = st;
    bus.ld_byte_valid = bv;
    bus.ld_byte       = b;
    bus.ld_done       = dn;
`ifdef IMEM_LOAD_CHECKSUM_EN
    if (st) csum_acc = 8'h00;
    else if (bv) csum_acc = csum_acc + b;
    bus.ld_csum_exp = csum_acc;
`endif
    tick();
    bus.ld_start      = 1'b0;
    bus.ld_byte_valid = 1'b0;
    bus.ld_done       = 1'b0;
  endtask

  task automatic drv_s(input logic st, input logic bv, input logic [7:0] b, input logic dn);
    sb.ld_start      = st;
    sb.ld_byte_valid = bv;
    sb.ld_byte       = b;
    sb.ld_done       = dn;
    tick();
    sb.ld_start      = 1'b0;
    sb.ld_byte_valid = 1'b0;
    sb.ld_done       = 1'b0;
  endtask

  // Monitor: every write and every fetch ack must match the head of its queue.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (bus.mem_we) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h data %0h", bus.mem_addr, bus.mem_wdata);
        end else begin
          chk("write", {bus.mem_addr, bus.mem_wdata}, wq.pop_front());
        end
      end
      if (sb.mem_we) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_small_write: addr %0h data %0h", sb.mem_addr, sb.mem_wdata);
        end else begin
          chk("small_write", {sb.mem_addr, sb.mem_wdata}, sq.pop_front());
        end
      end
      if (bus.f_ack) begin
        if (fq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: err %0b data %0h", bus.f_err, bus.f_data);
        end else begin
          chk("fetch", {31'h0, bus.f_err, bus.f_data}, fq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] t1 [8];
    t1 = '{8'h13, 8'h00, 8'h10, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00};
    for (int i = 0; i < 1024; i++) mem_a[i] = 32'hA500_0000 | 32'(i);
    for (int i = 0; i < 4; i++) mem_b[i] = 32'h0;

    reset = 1'b1;
    bus.ld_start = 1'b0; bus.ld_byte_valid = 1'b0; bus.ld_byte = 8'h0; bus.ld_done = 1'b0;
    bus.f_req = 1'b0; bus.f_addr = 32'h0;
    sb.ld_start = 1'b0; sb.ld_byte_valid = 1'b0; sb.ld_byte = 8'h0; sb.ld_done = 1'b0;
    sb.f_req = 1'b0; sb.f_addr = 32'h0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    bus.ld_csum_exp = 8'h00;
    sb.ld_csum_exp  = 8'h00;
`endif

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_hold", bus.core_hold, 1);
    chk("rst_ld_busy", bus.ld_busy, 0);
    chk("rst_ld_ovf", bus.ld_ovf, 0);
    chk("rst_word_count", bus.ld_word_count, 0);
    chk("rst_f_ack", bus.f_ack, 0);
    chk("rst_f_err", bus.f_err, 0);
    chk("rst_f_data", bus.f_data, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    reset = 1'b0;

    // IDLE ignores ld_done and fetch requests
    bus.f_req = 1'b1; bus.f_addr = 32'h0;
    drv(0, 0, 8'h00, 1);
    chk("idle_no_ack", bus.f_ack, 0);
    chk("idle_core_hold", bus.core_hold, 1);
    chk("idle_ld_busy", bus.ld_busy, 0);
    bus.f_req = 1'b0;

    // 4-word memory: 20 bytes -> 4 writes, the rest dropped with ld_ovf
    sq.push_back({32'd0,  32'h0403_0201});
    sq.push_back({32'd4,  32'h0807_0605});
    sq.push_back({32'd8,  32'h0C0B_0A09});
    sq.push_back({32'd12, 32'h100F_0E0D});
    drv_s(1, 0, 8'h00, 0);
    for (int i = 0; i < 20; i++) begin
      drv_s(0, 1, 8'(i + 1), 0);
      if (i == 15) begin
        chk("small_ovf_at_full", sb.ld_ovf, 0);
        chk("small_count_at_full", sb.ld_word_count, 4);
      end
    end
    chk("small_ovf", sb.ld_ovf, 1);
    chk("small_count", sb.ld_word_count, 4);
    drv_s(0, 0, 8'h00, 1);
    chk("small_count_after_done", sb.ld_word_count, 4);

    // Two full words then ld_done
    wq.push_back({32'd0, 32'h0010_0013});
    wq.push_back({32'd4, 32'h0020_81B3});
    drv(1, 0, 8'h00, 0);
    chk("t1_busy", bus.ld_busy, 1);
    chk("t1_hold", bus.core_hold, 1);
    for (int i = 0; i < 8; i++) drv(0, 1, t1[i], 0);
    chk("t1_hold_during_write", bus.core_hold, 1);
    drv(0, 0, 8'h00, 1);
    chk("t1_hold_released", bus.core_hold, 0);
    chk("t1_busy_low", bus.ld_busy, 0);
    chk("t1_count", bus.ld_word_count, 2);
`ifdef IMEM_LOAD_CHECKSUM_EN
    chk("t1_csum", bus.ld_csum, csum_acc);
`endif

    // Partial word padded in FLUSH
    wq.push_back({32'd0, 32'h0010_0093});
    drv(1, 0, 8'h00, 0);
    chk("t2_count_cleared", bus.ld_word_count, 0);
    chk("t2_hold", bus.core_hold, 1);
    drv(0, 1, 8'h93, 0);
    drv(0, 1, 8'h00, 0);
    drv(0, 1, 8'h10, 0);
    drv(0, 0, 8'h00, 1);
    chk("t2_flush_we", bus.mem_we, 1);
    chk("t2_flush_hold", bus.core_hold, 1);
    chk("t2_flush_busy", bus.ld_busy, 1);
    tick();
    chk("t2_run_hold", bus.core_hold, 0);
    chk("t2_count", bus.ld_word_count, 1);

    // Back-to-back fetches
    fq.push_back({31'h0, 1'b0, 32'h0010_0093});
    fq.push_back({31'h0, 1'b0, 32'h0020_81B3});
    fq.push_back({31'h0, 1'b0, 32'hA500_0002});
    bus.f_req = 1'b1;
    bus.f_addr = 32'd0; tick();
    chk("f_ack_1", bus.f_ack, 1);
    bus.f_addr = 32'd4; tick();
    chk("f_ack_2", bus.f_ack, 1);
    bus.f_addr = 32'd8; tick();
    chk("f_ack_3", bus.f_ack, 1);
    bus.f_req = 1'b0;
    tick();
    chk("f_ack_drop", bus.f_ack, 0);

    // Misaligned, out-of-range and last legal word
    fq.push_back({31'h0, 1'b1, 32'h0000_0013});
    fq.push_back({31'h0, 1'b1, 32'h0000_0013});
    fq.push_back({31'h0, 1'b0, 32'hA500_03FF});
    bus.f_req = 1'b1;
    bus.f_addr = 32'h2;
    #1 chk("misaligned_no_access", bus.mem_addr, 0);
    tick();
    bus.f_addr = 32'd4096;
    #1 chk("range_no_access", bus.mem_addr, 0);
    tick();
    bus.f_addr = 32'd4092;
    #1 chk("last_word_addr", bus.mem_addr, 32'd4092);
    tick();
    bus.f_req = 1'b0;
    tick();
    chk("err_ack_drop", bus.f_ack, 0);

    // Last byte coincides with ld_done: byte taken, write in FLUSH, then RUN
    wq.push_back({32'd0, 32'h0403_0201});
    drv(1, 0, 8'h00, 0);
    drv(0, 1, 8'h01, 0);
    drv(0, 1, 8'h02, 0);
    drv(0, 1, 8'h03, 0);
    drv(0, 1, 8'h04, 1);
    chk("combo_we", bus.mem_we, 1);
    chk("combo_hold", bus.core_hold, 1);
    tick();
    chk("combo_run", bus.core_hold, 0);
    chk("combo_count", bus.ld_word_count, 1);

    // Fetch in the same cycle as ld_start still gets its ack
    fq.push_back({31'h0, 1'b0, 32'h0020_81B3});
    bus.f_req = 1'b1; bus.f_addr = 32'd4;
    drv(1, 0, 8'h00, 0);
    bus.f_req = 1'b0;
    chk("start_fetch_ack", bus.f_ack, 1);
    chk("start_hold", bus.core_hold, 1);
    chk("start_busy", bus.ld_busy, 1);

    // Asynchronous reset after two bytes aborts the load
    drv(0, 1, 8'hAA, 0);
    drv(0, 1, 8'hBB, 0);
    #2 reset = 1'b1;
    #1;
    chk("abort_hold", bus.core_hold, 1);
    chk("abort_busy", bus.ld_busy, 0);
    chk("abort_count", bus.ld_word_count, 0);
    chk("abort_we", bus.mem_we, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 32'd0;
    tick();
    tick();
    chk("abort_no_ack", bus.f_ack, 0);
    chk("abort_idle_hold", bus.core_hold, 1);
    bus.f_req = 1'b0;
    tick();

    chk("write_queue_drained", 64'(wq.size()), 0);
    chk("small_queue_drained", 64'(sq.size()), 0);
    chk("fetch_queue_drained", 64'(fq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Owns the single port of the instruction memory and shares it between two requesters: a boot/program loader (byte stream from the I2C slave) and the core's instruction fetch.
- Assembles loader bytes into little-endian words and writes them sequentially from word 0.
- Holds the core stalled until the load completes, then serves fetch requests with a registered one-cycle response.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the instruction memory; legal byte addresses are 0 .. DEPTH_WORDS*4-1.
- CNT_W, 16, width of the loaded-word counter; CNT_W bits must be able to hold DEPTH_WORDS.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ld_start  in  1  pulse: begin a new program load.
- ld_byte_valid  in  1  ld_byte is valid this cycle.
- ld_byte  in  8  program byte, little-endian order.
- ld_done  in  1  pulse: end of program stream.
- ld_busy  out  1  high while in LOAD or FLUSH.
- ld_ovf  out  1  sticky: bytes were dropped because memory was full.
- ld_word_count  out  CNT_W  words written in the current or last load.
- core_hold  out  1  stall/reset request to the core; high unless in RUN.
- f_req  in  1  fetch request.
- f_addr  in  32  fetch byte address.
- f_ack  out  1  fetch response valid.
- f_data  out  32  fetched instruction.
- f_err  out  1  qualifies f_ack: address was misaligned or out of range.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; combinational read of mem_addr.

Behaviour:
- Reset values:
  - state=IDLE, core_hold=1, ld_busy=0, ld_ovf=0, ld_word_count=0.
  - f_ack=0, f_err=0, f_data=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Byte lane index=0.
  - Memory contents are not cleared.
- States:
  - IDLE: ld_start goes to LOAD. Fetch requests are ignored.
  - LOAD:
    - Each ld_byte_valid stores ld_byte into lane k, bits 8k+7:8k, then k increments.
    - When k=3 is filled, mem_we is asserted for exactly one cycle on the next cycle, with mem_addr=ld_word_count*4 and the assembled word on mem_wdata. ld_word_count then increments and k returns to 0.
    - ld_byte_valid may be high every cycle; no bytes are lost.
  - FLUSH (entered on ld_done):
    - If k!=0, unfilled lanes are set to 0x00 and one write is issued. FLUSH then goes to RUN next cycle.
    - If k=0, no write is issued and FLUSH goes to RUN immediately.
  - RUN: core_hold=0. Fetch is serviced. ld_start goes to LOAD next cycle, clears ld_word_count, ld_ovf and k, and raises core_hold.
- Simultaneous ld_byte_valid and ld_done: the byte is accepted first, then FLUSH.
- ld_done in IDLE is ignored. ld_start in LOAD or FLUSH restarts the load: partial word discarded, counters cleared.
- Full memory: with ld_word_count=DEPTH_WORDS, further bytes are dropped, ld_ovf=1 and no write is issued. There is no wrap-around.
- Fetch, RUN only:
  - f_req sampled at edge N drives mem_addr=f_addr combinationally in cycle N.
  - At edge N+1: f_ack=1 and f_data=mem_rdata. Latency is 1 cycle, with back-to-back throughput of one per cycle.
  - f_ack is deasserted the cycle after a cycle with no f_req.
  - If f_addr[1:0]!=0 or f_addr>=DEPTH_WORDS*4: f_ack=1, f_err=1, f_data=32'h00000013 (NOP), and memory is not accessed.
  - f_req outside RUN: no f_ack.
  - A fetch accepted in the same cycle as ld_start still receives its ack.
- Port priority: a loader write always owns mem_addr when mem_we=1. Fetch is never active outside RUN, so no conflict exists.
- Asynchronous reset mid-load aborts the load immediately. Outputs return to their reset values; any partial word is lost.

Optional Feature:
- IMEM_LOAD_CHECKSUM_EN defined:
  - Adds output ld_csum (8 bits): the modulo-256 sum of all accepted bytes in the current load, excluding FLUSH padding. Cleared on reset and on ld_start.
  - Adds input ld_csum_exp (8 bits), sampled on ld_done. On mismatch, the block goes from FLUSH back to IDLE instead of RUN, so core_hold stays 1.
- Not defined: neither port exists, and FLUSH always goes to RUN.

Test Plan:
- ld_start; bytes 13 00 10 00, then B3 81 20 00; ld_done -> two writes: addr 0 data 0x00100013, addr 4 data 0x002081B3; ld_word_count=2; core_hold falls one cycle after the last write.
- Bytes 93 00 10 then ld_done -> single write: addr 0 data 0x00100093; next cycle RUN.
- In RUN, f_req on addresses 0, 4, 8 on consecutive cycles -> f_ack high on 3 consecutive cycles; data matches memory; f_err=0.
- f_addr=0x2 and f_addr=DEPTH_WORDS*4 -> f_ack=1, f_err=1, f_data=0x00000013.
- DEPTH_WORDS=4: load 20 bytes -> 4 writes, ld_ovf=1, ld_word_count=4, no write issued to address 16.
- Assert reset after 2 bytes of a load -> core_hold=1, state IDLE, no write; a following f_req gives no f_ack.
